// File: rtl/sonar_echo_responder.sv
// rtl/sonar_echo_responder.sv - ultrasonic ranging sensor emulator: trig in, distance-encoded echo out
module sonar_echo_responder #(
    parameter int TRIG_MIN_CYC    = 1000,
    parameter int BURST_DELAY_CYC = 20000,
    parameter int CYC_PER_CM      = 5882,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYC     = 3800000,
    parameter int HOLDOFF_CYC     = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    input  logic       object_present,
    output logic       echo,
    output logic       busy,
    output logic       err_short_trig,
    output logic [7:0] meas_count
);

    localparam int CW = 23;
    localparam logic [CW-1:0] TRIG_MIN_L = CW'(TRIG_MIN_CYC);
    localparam logic [CW-1:0] BURST_L    = CW'(BURST_DELAY_CYC);
    localparam logic [CW-1:0] CPC_L      = CW'(CYC_PER_CM);
    localparam logic [CW-1:0] TIMEOUT_L  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLDOFF_L  = CW'(HOLDOFF_CYC);
    localparam logic [9:0]    MAX_CM_L   = 10'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t state;
    state_t next_state;

    logic          sync_s1;
    logic          sync_s2;
    logic          sync_s3;
    logic [1:0]    sync_ok;
    logic          armed;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt;
    logic [8:0]    dist_q;
    logic          obj_q;
    logic [CW-1:0] width_q;
    logic [8:0]    dist_eff;
    logic [CW-1:0] width_next;
    logic          accept;
    logic          reject;

    // sync_ok marks when sync_s2 holds a real sample rather than its reset value,
    // so a trig held high across reset is never mistaken for a fresh low-to-high edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_s1 <= trig;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & ~sync_s2);
            rise_q  <= armed & sync_s2 & ~sync_s3;
            fall_q  <= sync_s3 & ~sync_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (rise_q) begin
                    next_state = TRIG_HIGH;
                end
            end
            TRIG_HIGH: begin
                if (fall_q) begin
                    if (cnt >= TRIG_MIN_L) begin
                        next_state = BURST;
                        accept     = 1'b1;
                    end else begin
                        next_state = IDLE;
                        reject     = 1'b1;
                    end
                end
            end
            BURST: begin
                if (cnt == BURST_L) begin
                    next_state = ECHO;
                end
            end
            ECHO: begin
                if (cnt == width_q) begin
                    next_state = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLDOFF_L) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One shared counter: loads 1 on every state entry so that in each timed state
    // it equals the number of cycles spent there, saturating instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= CW'(1);
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        dist_eff   = (dist_q < 9'd2) ? 9'd2 : dist_q;
        width_next = CW'(dist_eff) * CPC_L;
        if (!obj_q || ({1'b0, dist_q} > MAX_CM_L)) begin
            width_next = TIMEOUT_L;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_q  <= '0;
            obj_q   <= 1'b0;
            width_q <= '0;
        end else begin
            if (accept) begin
                dist_q <= dist_cm;
                obj_q  <= object_present;
            end
            if (state == BURST) begin
                width_q <= width_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo           <= 1'b0;
            err_short_trig <= 1'b0;
            meas_count     <= '0;
        end else begin
            echo           <= (next_state == ECHO);
            err_short_trig <= reject;
            if (state == ECHO && next_state == HOLDOFF) begin
                meas_count <= meas_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sonar_echo_responder.sv
// tb/tb_sonar_echo_responder.sv - directed scoreboard bench for sonar_echo_responder
module tb_sonar_echo_responder;

    localparam int TMIN = 10;
    localparam int BD   = 20;
    localparam int CPC  = 3;
    localparam int MAXC = 40;
    localparam int TO   = 150;
    localparam int HO   = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [8:0] dist_cm;
    logic       object_present;
    logic       echo;
    logic       busy;
    logic       err_short_trig;
    logic [7:0] meas_count;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int err_pulses = 0;
    int exp_meas = 0;

    sonar_echo_responder #(
        .TRIG_MIN_CYC   (TMIN),
        .BURST_DELAY_CYC(BD),
        .CYC_PER_CM     (CPC),
        .MAX_CM         (MAXC),
        .TIMEOUT_CYC    (TO),
        .HOLDOFF_CYC    (HO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trig          (trig),
        .dist_cm       (dist_cm),
        .object_present(object_present),
        .echo          (echo),
        .busy          (busy),
        .err_short_trig(err_short_trig),
        .meas_count    (meas_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_short_trig) err_pulses++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_width(input int d, input bit obj);
        if (!obj || d > MAXC) return TO;
        return ((d < 2) ? 2 : d) * CPC;
    endfunction

    task automatic fire(input int hi);
        @(negedge clk) trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic launch(input int d, input bit obj, input int hi);
        dist_cm        = 9'(d);
        object_present = obj;
        exp_q.push_back(model_width(d, obj));
        fire(hi);
    endtask

    // Called right after the trig fall; counts edges from the first low sample.
    task automatic measure(input string tag, input bit disturb);
        int k;
        int w;
        int exp_w;
        int err_before;
        bit got;
        exp_w      = exp_q.pop_front();
        err_before = err_pulses;
        k          = 0;
        got        = 1'b0;
        while (k < BD + 100 && !got) begin
            @(posedge clk); #1;
            k++;
            if (echo) got = 1'b1;
        end
        check({tag, "_rise"}, int'(got), 1);
        if (got) begin
            check({tag, "_latency"}, k - 1, BD + 3);
            w = 0;
            while (echo && w < TO + 100) begin
                @(posedge clk); #1;
                w++;
                if (disturb && w == 5) begin
                    dist_cm = 9'd50;
                    trig    = 1'b1;
                end
                if (disturb && w == 20) trig = 1'b0;
            end
            check({tag, "_width"}, w, exp_w);
            exp_meas = (exp_meas + 1) % 256;
            check({tag, "_meas"}, int'(meas_count), exp_meas);
            check({tag, "_no_err"}, err_pulses - err_before, 0);
        end
    endtask

    task automatic wait_idle(input string tag, input int exp_cyc);
        int k;
        k = 0;
        while (busy && k < HO + 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_cyc >= 0) check({tag, "_holdoff"}, k, exp_cyc);
        else check({tag, "_idle"}, int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int err_before;
        int seen_echo;
        int seen_busy;
        int case_d[5]   = '{41, 5, 0, 40, 1};
        bit case_obj[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst            = 1'b1;
        trig           = 1'b0;
        dist_cm        = '0;
        object_present = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err_short_trig), 0);
        check("reset_meas", int'(meas_count), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Minimum accepted trig width, nominal distance.
        launch(10, 1'b1, TMIN);
        measure("basic", 1'b0);
        wait_idle("basic", HO);

        // One cycle too short: rejected with a single error pulse.
        err_before = err_pulses;
        seen_echo  = 0;
        fire(TMIN - 1);
        repeat (20) begin
            @(posedge clk); #1;
            if (echo) seen_echo++;
        end
        check("short_err_pulses", err_pulses - err_before, 1);
        check("short_no_echo", seen_echo, 0);
        check("short_busy", int'(busy), 0);
        check("short_meas", int'(meas_count), exp_meas);

        // Out of range, no target, below-minimum distance, range limit, one cm.
        for (int i = 0; i < 5; i++) begin
            launch(case_d[i], case_obj[i], TMIN + 3);
            measure($sformatf("case%0d", i), 1'b0);
            wait_idle($sformatf("case%0d", i), -1);
        end

        // Retrigger and distance change while echo is high must not disturb it.
        launch(20, 1'b1, TMIN);
        measure("disturb", 1'b1);
        wait_idle("disturb", -1);
        seen_busy = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) seen_busy++;
        end
        check("disturb_no_restart", seen_busy, 0);

        // Asynchronous reset in the middle of an echo, trig held high through release.
        dist_cm        = 9'd30;
        object_present = 1'b1;
        fire(TMIN);
        seen_echo = 0;
        for (int k = 0; k < BD + 100 && seen_echo == 0; k++) begin
            @(posedge clk); #1;
            if (echo) seen_echo = 1;
        end
        check("rst_echo_started", seen_echo, 1);
        repeat (10) @(posedge clk);
        #2;
        trig = 1'b1;
        rst  = 1'b1;
        #1;
        check("rst_async_echo", int'(echo), 0);
        check("rst_async_meas", int'(meas_count), 0);
        check("rst_async_busy", int'(busy), 0);
        exp_meas = 0;
        @(negedge clk) rst = 1'b0;
        seen_echo = 0;
        seen_busy = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (echo) seen_echo++;
            if (busy) seen_busy++;
        end
        check("rst_held_trig_no_echo", seen_echo, 0);
        check("rst_held_trig_no_busy", seen_busy, 0);
        @(negedge clk) trig = 1'b0;
        repeat (5) @(negedge clk);
        launch(7, 1'b1, TMIN);
        measure("after_rst", 1'b0);
        wait_idle("after_rst", HO);
        check("total_err_pulses", err_pulses, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_echo_responder.md
SONAR_ECHO_RESPONDER -- requirements
Module: sonar_echo_responder

Interface
REQ-001 SHALL provide parameter TRIG_MIN_CYC, default 1000, minimum valid trig high time in clk cycles (10 us at 100 MHz).
REQ-002 SHALL provide parameter BURST_DELAY_CYC, default 20000, delay from accepted trig fall to echo rise (200 us burst time).
REQ-003 SHALL provide parameter CYC_PER_CM, default 5882, echo high cycles per cm of target distance (58.82 us/cm round trip).
REQ-004 SHALL provide parameter MAX_CM, default 400, largest distance reported as a detected target.
REQ-005 SHALL provide parameter TIMEOUT_CYC, default 3800000, echo width for no target or out-of-range (38 ms).
REQ-006 SHALL provide parameter HOLDOFF_CYC, default 2000000, dead time after echo fall before a new trig is accepted.
REQ-007 clk  input  1  100 MHz system clock; all logic on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 trig  input  1  asynchronous trigger from the ranging initiator.
REQ-010 dist_cm  input  9  emulated target distance in cm, unsigned.
REQ-011 object_present  input  1  1 = target present, 0 = no echo target.
REQ-012 echo  output  1  echo pulse; width encodes distance.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 err_short_trig  output  1  one-cycle pulse on rejected short trig.
REQ-015 meas_count  output  8  count of completed echo pulses.

Function
REQ-016 trig SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal only.
REQ-017 State machine SHALL have exactly five states: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
REQ-018 IDLE -> TRIG_HIGH SHALL occur only on a synchronized trig rising edge; a trig already high on entry to IDLE SHALL be ignored until it falls and rises again.
REQ-019 TRIG_HIGH SHALL count high cycles in a 23-bit counter that saturates rather than wraps.
REQ-020 On synchronized trig fall with count >= TRIG_MIN_CYC, the FSM SHALL enter BURST and capture dist_cm and object_present in the same cycle.
REQ-021 On synchronized trig fall with count < TRIG_MIN_CYC, the FSM SHALL return to IDLE and pulse err_short_trig for exactly one cycle.
REQ-022 BURST SHALL last exactly BURST_DELAY_CYC cycles, then enter ECHO.
REQ-023 echo SHALL be registered, rise in the first ECHO cycle, and remain high for exactly W cycles.
REQ-024 W SHALL be TIMEOUT_CYC if captured object_present = 0 or captured dist_cm > MAX_CM; otherwise max(captured dist_cm, 2) * CYC_PER_CM.
REQ-025 The product SHALL be computed at least 23 bits wide without truncation; 400 * 5882 = 2352800 fits.
REQ-026 After echo falls, the FSM SHALL enter HOLDOFF for exactly HOLDOFF_CYC cycles, then IDLE.
REQ-027 meas_count SHALL increment on each echo fall and wrap from 255 to 0.
REQ-028 trig activity in BURST, ECHO or HOLDOFF SHALL be ignored and SHALL NOT set err_short_trig.
REQ-029 dist_cm and object_present changes after capture SHALL NOT affect the pulse in progress.
REQ-030 End-to-end latency SHALL be fixed: echo rises BURST_DELAY_CYC + 3 clk cycles after the first clk edge at which raw trig is sampled low.

Reset
REQ-031 rst high SHALL immediately and asynchronously force state IDLE, with echo, busy, err_short_trig, meas_count, all counters and synchronizer flops at 0.
REQ-032 rst asserted mid-ECHO SHALL drop echo without waiting for a clock edge and SHALL NOT increment meas_count.
REQ-033 After rst release, the FSM SHALL require a fresh synchronized trig rising edge before starting.

Verification
REQ-034 trig high 1000 cycles, dist_cm=10, object_present=1 -> echo rises 20003 cycles after trig fall, high 58820 cycles; meas_count 0->1; busy low 2000000 cycles after echo fall.
REQ-035 trig high 999 cycles -> err_short_trig high exactly 1 cycle, echo stays 0, busy returns low, meas_count unchanged.
REQ-036 Three cases: dist_cm=401 with object_present=1; object_present=0; dist_cm=0 -> echo widths 3800000, 3800000 and 11764 cycles.
REQ-037 Second trig pulse issued during ECHO, and dist_cm changed to 50 during ECHO -> no restart, echo width unchanged, no err_short_trig.
REQ-038 rst pulsed at cycle 1000 of ECHO -> echo 0 before the next clk edge, meas_count 0; trig held high through release yields no echo until trig toggles low then high.
